// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a master and the apb_slave_regfile slave.
// The pstrb lane is only present when APB_PSTRB_EN is defined.
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

`ifdef APB_PSTRB_EN
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
`else
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
`endif
endinterface

// File: rtl/apb_slave_regfile.sv
// APB slave with a NUM_REGS x DATA_WIDTH register file, programmable wait
// states, PSLVERR on out-of-range index and abort when the master drops
// PSEL/PENABLE before the transfer completes.
// Optional feature: define APB_PSTRB_EN to add byte strobes (pstrb); a read
// with any strobe bit set then reports PSLVERR.
module apb_slave_regfile #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_slave_regfile_if.slave bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  // The wait counter is 4 bits wide, so larger settings cannot be honoured.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_slave_regfile: WAIT_STATES must be in 0..15");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("apb_slave_regfile: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_REGS < 1 || NUM_REGS > 2**ADDR_WIDTH) begin : g_bad_regs
    $error("apb_slave_regfile: NUM_REGS must be in 1..2**ADDR_WIDTH");
  end

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  ready;
  logic                  commit;
  logic                  range_err;
  logic                  err;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  assign idx       = bus.paddr[IDX_W-1:0];
  assign range_err = ({1'b0, bus.paddr} >= NUM_REGS_W);

  // A read carrying strobes is an APB4 protocol error; writes only fail on range.
`ifdef APB_PSTRB_EN
  assign err = range_err | (!bus.pwrite && (bus.pstrb != '0));
`else
  assign err = range_err;
`endif

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state: setup enters ACCESS, ready completes, dropped strobes abort.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_next = ACCESS;
          cnt_next   = WAIT_INIT;
        end
      end
      ACCESS: begin
        ready = (cnt == 4'd0);
        if (!bus.psel || !bus.penable) begin
          state_next = IDLE;
        end else if (ready) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Register file: writes land only on a completing, in-range write transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && bus.pwrite && !range_err) begin
`ifdef APB_PSTRB_EN
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (bus.pstrb[b]) begin
          regs[idx][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
        end
      end
`else
      regs[idx] <= bus.pwdata;
`endif
    end
  end

  assign bus.pready  = ready;
  assign bus.pslverr = ready & err;
  assign bus.prdata  = (ready && !bus.pwrite && !err) ? regs[idx] : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: three instances with 0, 2 and 3
// wait states share one driver; only the targeted instance sees PSEL.
// Define APB_PSTRB_EN to also exercise byte strobes.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst_n;
  logic [1:0]  target;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        rdy;
  logic        slverr;
  logic [31:0] rd;

  int checks;
  int errors;
  int wait_of [3] = '{0, 2, 3};
  logic [31:0] model [3][16];

  apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
  apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();
  apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus2 ();

  apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(0))
    u_w0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(2))
    u_w2 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(3))
    u_w3 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.psel = psel && (target == 2'd0);
  assign bus1.psel = psel && (target == 2'd1);
  assign bus2.psel = psel && (target == 2'd2);
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus2.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus2.pwrite = pwrite;
  assign bus0.paddr = paddr;
  assign bus1.paddr = paddr;
  assign bus2.paddr = paddr;
  assign bus0.pwdata = pwdata;
  assign bus1.pwdata = pwdata;
  assign bus2.pwdata = pwdata;
`ifdef APB_PSTRB_EN
  assign bus0.pstrb = pstrb;
  assign bus1.pstrb = pstrb;
  assign bus2.pstrb = pstrb;
`endif

  // Observe the outputs of whichever instance is currently targeted.
  always_comb begin
    case (target)
      2'd0:    begin rdy = bus0.pready; slverr = bus0.pslverr; rd = bus0.prdata; end
      2'd1:    begin rdy = bus1.pready; slverr = bus1.pslverr; rd = bus1.prdata; end
      default: begin rdy = bus2.pready; slverr = bus2.pslverr; rd = bus2.prdata; end
    endcase
  end

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected error flag from the access rules.
  function automatic logic model_err(input logic wr, input logic [7:0] addr,
                                     input logic [3:0] strb);
    logic e;
    e = (addr >= 8'd16);
`ifdef APB_PSTRB_EN
    if (!wr && strb != 4'h0) e = 1'b1;
`else
    e = e | (wr & 1'b0) | (|strb & 1'b0);
`endif
    return e;
  endfunction

  // Expected register value after a write: strobed byte lanes replace old bytes.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] mask;
`ifdef APB_PSTRB_EN
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`else
    mask = 32'hFFFF_FFFF | {28'h0, strb & 4'h0};
`endif
    return (old & ~mask) | (data & mask);
  endfunction

  // One full APB transfer with every cycle of the ACCESS phase checked.
  task automatic applyStimulus(input logic [1:0] inst, input logic wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input string tag);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          waits;
    bit          done;
    exp_err = model_err(wr, addr, strb);
    exp_rd  = (!wr && !exp_err) ? model[inst][addr[3:0]] : 32'h0;
    @(negedge clk);
    target = inst; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    #1;
    check({tag, ":setup_ready"}, {31'h0, rdy}, 32'h0);
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (rdy) begin
        done = 1'b1;
      end else begin
        check({tag, ":wait_rdata"}, rd, 32'h0);
        check({tag, ":wait_slverr"}, {31'h0, slverr}, 32'h0);
        waits++;
        @(negedge clk);
      end
    end
    check({tag, ":ready_seen"}, {31'h0, done}, 32'h1);
    check({tag, ":waits"}, waits, wait_of[inst]);
    if (done) begin
      checkOutput(tag, exp_rd, exp_err);
      @(posedge clk);
      if (wr && !exp_err) model[inst][addr[3:0]] = merge(model[inst][addr[3:0]], data, strb);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    check({tag, ":prdata"}, rd, exp_rd);
    check({tag, ":pslverr"}, {31'h0, slverr}, {31'h0, exp_err});
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [1:0] ri;
    logic       rw;
    logic [7:0] ra;
    checks = 0; errors = 0;
    rst_n = 1'b0; target = 2'd0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
    for (int i = 0; i < 3; i++) for (int r = 0; r < 16; r++) model[i][r] = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", {31'h0, rdy}, 32'h0);
    check("reset_prdata", rd, 32'h0);

    // Fill every register of every instance with random data.
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 16; r++)
        applyStimulus(2'(i), 1'b1, 8'(r), $urandom | 32'h1, 4'hF, "fill");

    // Reset while the 3-wait instance holds a ready read on the bus.
    @(negedge clk);
    target = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd4; pstrb = 4'h0;
    @(negedge clk);
    penable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_ready", {31'h0, rdy}, 32'h1);
    check("pre_reset_prdata", rd, model[2][4]);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ready", {31'h0, rdy}, 32'h0);
    check("mid_reset_slverr", {31'h0, slverr}, 32'h0);
    check("mid_reset_prdata", rd, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) for (int r = 0; r < 16; r++) model[i][r] = 32'h0;
    for (int r = 0; r < 16; r++) applyStimulus(2'd2, 1'b0, 8'(r), 32'h0, 4'h0, "post_reset_rd");

    // Zero-wait write then read back, back-to-back.
    applyStimulus(2'd0, 1'b1, 8'd3, 32'h0000_00A5, 4'hF, "w0_wr3");
    applyStimulus(2'd0, 1'b0, 8'd3, 32'h0, 4'h0, "w0_rd3");
    check("w0_rd3_value", model[0][3], 32'h0000_00A5);

    // Two-wait read of index 3.
    applyStimulus(2'd1, 1'b1, 8'd3, 32'h0000_003C, 4'hF, "w2_wr3");
    applyStimulus(2'd1, 1'b0, 8'd3, 32'h0, 4'h0, "w2_rd3");

    // Out-of-range index on every instance leaves the file untouched.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'(i), 1'b1, 8'd16, 32'h0000_005A, 4'hF, "oor_wr");
      applyStimulus(2'(i), 1'b0, 8'd16, 32'h0, 4'h0, "oor_rd");
    end
    applyStimulus(2'd0, 1'b0, 8'd255, 32'h0, 4'h0, "oor_rd255");
    for (int r = 0; r < 16; r++) applyStimulus(2'd0, 1'b0, 8'(r), 32'h0, 4'h0, "oor_scan");

    // Abort: drop PSEL two cycles into a 3-wait write to index 5.
    applyStimulus(2'd2, 1'b1, 8'd5, 32'h1234_5678, 4'hF, "abort_pre");
    @(negedge clk);
    target = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("abort_ready_1", {31'h0, rdy}, 32'h0);
    @(negedge clk);
    #1;
    check("abort_ready_2", {31'h0, rdy}, 32'h0);
    check("abort_slverr", {31'h0, slverr}, 32'h0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    applyStimulus(2'd2, 1'b0, 8'd5, 32'h0, 4'h0, "abort_rd5");

`ifdef APB_PSTRB_EN
    // Byte strobes on the zero-wait instance.
    applyStimulus(2'd0, 1'b1, 8'd1, 32'h1122_3344, 4'hF, "strb_init");
    applyStimulus(2'd0, 1'b1, 8'd1, 32'hAABB_CCDD, 4'b0101, "strb_wr");
    applyStimulus(2'd0, 1'b0, 8'd1, 32'h0, 4'h0, "strb_rd");
    check("strb_value", model[0][1], 32'h11BB_33DD);
    applyStimulus(2'd0, 1'b1, 8'd1, 32'hFFFF_FFFF, 4'h0, "strb_none");
    applyStimulus(2'd0, 1'b0, 8'd1, 32'h0, 4'b0010, "strb_rd_err");
    applyStimulus(2'd0, 1'b0, 8'd1, 32'h0, 4'h0, "strb_rd2");
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      ri = 2'($urandom_range(0, 2));
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      applyStimulus(ri, rw, ra, $urandom, rw ? 4'($urandom) : (($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0), "rand");
    end
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
